// File: rtl/cpu_step_ctrl.sv
// Execution-enable controller: turns slow divider ticks or debounced button
// presses into single-cycle cpu_en pulses on the 100 MHz clock, and counts them.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_100Mhz,
  input  logic             reset_n,
  input  logic             clk_1Hz,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             sw_halt,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b11
  } state_e;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer bit order: {sw_halt, sw_run, btn_step, clk_1Hz}.
  logic [3:0]       sync1_q, sync2_q;
  logic             clk_1hz_d_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_prev_q;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;

  logic clk_1hz_s, btn_step_s, sw_run_s, sw_halt_s, tick;

  assign clk_1hz_s  = sync2_q[0];
  assign btn_step_s = sync2_q[1];
  assign sw_run_s   = sync2_q[2];
  assign sw_halt_s  = sync2_q[3];
  assign tick       = clk_1hz_s & ~clk_1hz_d_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_step_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_step_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign press_d = btn_db_q & ~btn_db_prev_q;

  // Events are judged against the current state; halt suppresses them outright.
  always_comb begin
    state_d      = state_q;
    cpu_en_d     = 1'b0;
    step_count_d = step_count_q;
    if (sw_halt_s) begin
      state_d = HALT;
    end else begin
      case (state_q)
        HALT: state_d = sw_run_s ? RUN : IDLE;
        IDLE: begin
          cpu_en_d = press_q;
          if (sw_run_s) state_d = RUN;
        end
        RUN: begin
          cpu_en_d = tick;
          if (!sw_run_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (cpu_en_d) step_count_d = step_count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      clk_1hz_d_q   <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      press_q       <= 1'b0;
      state_q       <= IDLE;
      cpu_en_q      <= 1'b0;
      step_count_q  <= '0;
    end else begin
      sync1_q       <= {sw_halt, sw_run, btn_step, clk_1Hz};
      sync2_q       <= sync1_q;
      clk_1hz_d_q   <= clk_1hz_s;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      press_q       <= press_d;
      state_q       <= state_d;
      cpu_en_q      <= cpu_en_d;
      step_count_q  <= step_count_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign step_count = step_count_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: expected pulses (cycle, count) are queued
// when stimulus is applied and matched by a negedge monitor.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_1Hz, btn_step, sw_run, sw_halt;
  logic        cpu_en;
  logic [15:0] step_count;
  logic [1:0]  mode;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt = 16'h0000;
  logic        en_prev = 1'b0;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk_100Mhz (clk),
    .reset_n    (reset_n),
    .clk_1Hz    (clk_1Hz),
    .btn_step   (btn_step),
    .sw_run     (sw_run),
    .sw_halt    (sw_halt),
    .cpu_en     (cpu_en),
    .step_count (step_count),
    .mode       (mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse: cpu_en seen at the negedge after edge cyc+lat.
  task automatic expect_pulse(input int lat);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.cyc = cyc + lat;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cpu_en === 1'b1) begin
      check("en_single_cycle", {31'b0, en_prev}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'b0, cpu_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", {16'b0, step_count}, {16'b0, e.cnt});
      end
    end
    en_prev = cpu_en;
  end

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clk_1Hz = 1'b0; btn_step = 1'b0; sw_run = 1'b0; sw_halt = 1'b0;

    // Reset held with every input toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clk_1Hz = ~clk_1Hz; btn_step = ~btn_step; sw_run = ~sw_run; sw_halt = ~sw_halt;
      check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
      check("rst_count", {16'b0, step_count}, 32'd0);
      check("rst_mode", {30'b0, mode}, 32'd0);
    end
    @(negedge clk);
    clk_1Hz = 1'b0; btn_step = 1'b0; sw_run = 1'b0; sw_halt = 1'b0;
    reset_n = 1'b1;
    wait_cycles(4);
    check("idle_mode", {30'b0, mode}, 32'd0);

    // Single step: 10-cycle press, pulse 8 edges later.
    btn_step = 1'b1;
    expect_pulse(8);
    wait_cycles(10);
    btn_step = 1'b0;
    wait_cycles(12);
    check("step_count_1", {16'b0, step_count}, 32'd1);
    check("step_sb_empty", sb.size(), 32'd0);

    // Bounce: runs shorter than the debounce interval.
    begin
      logic [6:0] pat;
      pat = 7'b1010110;
      for (int i = 6; i >= 0; i--) begin
        btn_step = pat[i];
        wait_cycles(1);
      end
    end
    btn_step = 1'b0;
    wait_cycles(12);
    check("bounce_count", {16'b0, step_count}, 32'd1);

    // Free run: ticks every 40 cycles, button presses ignored.
    sw_run = 1'b1;
    wait_cycles(3);
    check("run_mode", {30'b0, mode}, 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (i % 20 == 19) begin
        clk_1Hz = ~clk_1Hz;
        if (clk_1Hz) expect_pulse(3);
      end
      btn_step = (i >= 30 && i < 45);
      wait_cycles(1);
    end
    wait_cycles(5);
    check("run_count", {16'b0, step_count}, 32'd6);
    check("run_sb_empty", sb.size(), 32'd0);
    check("run_mode_end", {30'b0, mode}, 32'd1);

    // Halt lands on the FSM one cycle ahead of the tick.
    sw_halt = 1'b1;
    wait_cycles(1);
    clk_1Hz = 1'b1;
    wait_cycles(6);
    check("halt_mode", {30'b0, mode}, 32'd3);
    check("halt_count", {16'b0, step_count}, 32'd6);
    clk_1Hz = 1'b0;
    wait_cycles(5);
    sw_halt = 1'b0;
    wait_cycles(3);
    check("resume_mode", {30'b0, mode}, 32'd1);
    clk_1Hz = 1'b1;
    expect_pulse(3);
    wait_cycles(6);
    clk_1Hz = 1'b0;
    check("resume_count", {16'b0, step_count}, 32'd7);
    check("resume_sb_empty", sb.size(), 32'd0);

    // Wrap: preload the counter to all ones, then one press.
    sw_run = 1'b0;
    wait_cycles(3);
    check("wrap_idle_mode", {30'b0, mode}, 32'd0);
    force dut.step_count_q = 16'hFFFF;
    wait_cycles(1);
    release dut.step_count_q;
    wait_cycles(1);
    exp_cnt = 16'hFFFF;
    check("preload_count", {16'b0, step_count}, 32'h0000FFFF);
    btn_step = 1'b1;
    expect_pulse(8);
    wait_cycles(8);
    check("wrap_en_high", {31'b0, cpu_en}, 32'd1);
    check("wrap_count", {16'b0, step_count}, 32'd0);

    // Asynchronous reset while cpu_en is high, between clock edges.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_en", {31'b0, cpu_en}, 32'd0);
    check("async_rst_mode", {30'b0, mode}, 32'd0);
    btn_step = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    exp_cnt = 16'h0000;
    wait_cycles(12);
    check("post_rst_count", {16'b0, step_count}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
